// File: rtl/output_word_assembler.sv
// Reassembles the accelerator's narrow output byte stream into DATA_WIDTH-bit
// words and tags each word with lane index, last-lane and last-frame flags.
module output_word_assembler #(
  parameter  int IN_WIDTH     = 8,
  parameter  int DATA_WIDTH   = 32,
  parameter  int VECTOR_LANES = 16,
  parameter  int MAX_VECTORS  = 256,
  parameter  int CNT_WIDTH    = $clog2(MAX_VECTORS + 1),
  localparam int LANE_W       = $clog2(VECTOR_LANES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  cfg_num_vectors,
  input  logic [IN_WIDTH-1:0]   in_data,
  input  logic                  in_vld,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [LANE_W-1:0]     out_lane,
  output logic                  out_last_lane,
  output logic                  out_last_frame,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic                  busy,
  output logic                  done
);

  localparam int BYTES  = DATA_WIDTH / IN_WIDTH;
  localparam int BCNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int TOT_W  = $clog2(MAX_VECTORS * VECTOR_LANES + 1);

  localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES - 1);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(VECTOR_LANES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                state;
  logic [BCNT_W-1:0]     byte_cnt;
  logic [TOT_W-1:0]      word_cnt;
  logic [TOT_W-1:0]      last_idx;
  logic [LANE_W-1:0]     lane_cnt;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] full_word;
  logic [CNT_WIDTH-1:0]  num_vectors;
  logic [TOT_W-1:0]      total_words;
  logic                  accept;
  logic                  complete;
  logic                  out_fire;

  always_comb begin
    num_vectors = cfg_num_vectors;
    if (cfg_num_vectors > CNT_WIDTH'(MAX_VECTORS)) begin
      num_vectors = CNT_WIDTH'(MAX_VECTORS);
    end
    total_words = TOT_W'(num_vectors) * TOT_W'(VECTOR_LANES);
  end

  // Only the completing byte can be refused: it needs the output register free
  // (or being emptied this very cycle).
  assign in_rdy   = (state == RUN) && !((byte_cnt == LAST_BYTE) && out_vld && !out_rdy);
  assign accept   = in_vld && in_rdy;
  assign complete = accept && (byte_cnt == LAST_BYTE);
  assign out_fire = out_vld && out_rdy;

  // NOTE: give every always_comb output a full default first so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    full_word = acc;
    full_word[DATA_WIDTH-1 -: IN_WIDTH] = in_data;
  end

  // NOTE: the assembly buffer is pure datapath and carries no reset; byte_cnt
  // decides which slices are meaningful, so stale contents are never emitted.
  always_ff @(posedge clk) begin
    if (accept) begin
      acc[byte_cnt*IN_WIDTH +: IN_WIDTH] <= in_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side below sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      byte_cnt       <= '0;
      word_cnt       <= '0;
      last_idx       <= '0;
      lane_cnt       <= '0;
      out_data       <= '0;
      out_lane       <= '0;
      out_last_lane  <= 1'b0;
      out_last_frame <= 1'b0;
      out_vld        <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      done <= 1'b0;

      if (out_fire) begin
        out_vld <= 1'b0;
      end

      // A completing byte refills the register even if it is emptied this cycle.
      if (complete) begin
        out_data       <= full_word;
        out_lane       <= lane_cnt;
        out_last_lane  <= (lane_cnt == LAST_LANE);
        out_last_frame <= (word_cnt == last_idx);
        out_vld        <= 1'b1;
        word_cnt       <= word_cnt + 1'b1;
        lane_cnt       <= (lane_cnt == LAST_LANE) ? '0 : lane_cnt + 1'b1;
      end

      if (accept) begin
        byte_cnt <= (byte_cnt == LAST_BYTE) ? '0 : byte_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            if (num_vectors == '0) begin
              done <= 1'b1;
            end else begin
              state    <= RUN;
              busy     <= 1'b1;
              last_idx <= total_words - TOT_W'(1);
              word_cnt <= '0;
              lane_cnt <= '0;
              byte_cnt <= '0;
            end
          end
        end
        RUN: begin
          if (complete && (word_cnt == last_idx)) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_fire && out_last_frame) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_output_word_assembler.sv
// Bench for output_word_assembler: table of frame scenarios driven against a
// byte-queue reference model, plus hand-written reset and backpressure sequences.
module tb_output_word_assembler;

  localparam int LANES   = 16;
  localparam int MAX_VEC = 256;

  typedef enum int {RDY_ALWAYS, RDY_RANDOM, RDY_STALL} rdy_mode_e;
  typedef enum int {PAT_INC, PAT_RAND, PAT_AA} pat_e;

  typedef struct {
    int          cfg;
    rdy_mode_e   mode;
    pat_e        pat;
    bit          restart;
    int          exp_words;
    bit          has_fl;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
  } frame_vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [8:0]  cfg_num_vectors;
  logic [7:0]  in_data;
  logic        in_vld;
  logic        in_rdy;
  logic [31:0] out_data;
  logic [3:0]  out_lane;
  logic        out_last_lane;
  logic        out_last_frame;
  logic        out_vld;
  logic        out_rdy;
  logic        busy;
  logic        done;

  int pass_cnt  = 0;
  int check_cnt = 0;

  logic [7:0]  byte_q[$];
  int          cur_total;
  logic [31:0] cap_first;
  logic [31:0] cap_last;

  frame_vec_t vecs[7];

  output_word_assembler dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .cfg_num_vectors (cfg_num_vectors),
    .in_data         (in_data),
    .in_vld          (in_vld),
    .in_rdy          (in_rdy),
    .out_data        (out_data),
    .out_lane        (out_lane),
    .out_last_lane   (out_last_lane),
    .out_last_frame  (out_last_frame),
    .out_vld         (out_vld),
    .out_rdy         (out_rdy),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    check_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: word k is bytes 4k..4k+3 packed little-endian.
  function automatic logic [31:0] model_word(input int k);
    return {byte_q[4*k+3], byte_q[4*k+2], byte_q[4*k+1], byte_q[4*k]};
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_out_data"}, 64'(out_data), 64'd0);
    check({tag, "_flags"}, 64'({out_lane, out_last_lane, out_last_frame, out_vld}), 64'd0);
    check({tag, "_busy_done_rdy"}, 64'({busy, done, in_rdy}), 64'd0);
  endtask

  task automatic run_frame(input frame_vec_t v, output int nwords);
    int  nvec;
    int  nbytes;
    int  idx;
    int  k;
    int  cyc;
    int  pend;
    int  budget;
    int  bubbles;
    int  drain_err;
    bit  after_last;
    bit  finished;

    nvec      = (v.cfg > MAX_VEC) ? MAX_VEC : v.cfg;
    cur_total = nvec * LANES;
    nbytes    = cur_total * 4;
    byte_q.delete();
    for (int i = 0; i < nbytes; i++) begin
      case (v.pat)
        PAT_RAND: byte_q.push_back(8'($urandom));
        PAT_AA:   byte_q.push_back((i == 0) ? 8'hAA : 8'(i));
        default:  byte_q.push_back(8'(i));
      endcase
    end

    // Start pulse from IDLE, with a byte waiting that must not be taken.
    @(negedge clk);
    start           = 1'b1;
    cfg_num_vectors = 9'(v.cfg);
    in_vld          = 1'b1;
    in_data         = 8'h55;
    out_rdy         = 1'b1;
    #1;
    check("idle_in_rdy", 64'(in_rdy), 64'd0);

    nwords = 0;
    if (cur_total == 0) begin
      @(negedge clk);
      start  = 1'b0;
      in_vld = 1'b0;
      #1;
      check("zero_done", 64'({done, busy, in_rdy}), 64'b100);
      @(negedge clk);
      #1;
      check("zero_done_clear", 64'({done, busy}), 64'd0);
      return;
    end

    idx = 0; k = 0; cyc = 0; pend = -1; bubbles = 0; drain_err = 0;
    after_last = 1'b0; finished = 1'b0;
    budget = nbytes * 8 + 200;
    while (!finished && cyc < budget) begin
      @(negedge clk);
      if (cyc == 0) check("start_busy", 64'({busy, done}), 64'b10);
      if (pend >= 0) begin
        check("load_vld", 64'(out_vld), 64'd1);
        check("load_data", 64'(out_data), 64'(model_word(pend)));
        pend = -1;
      end
      if (after_last) begin
        in_vld = 1'b0;
        start  = 1'b0;
        #1;
        check("end_done_busy_rdy", 64'({done, busy, in_rdy}), 64'b100);
        finished = 1'b1;
        break;
      end
      start           = v.restart && (cyc == 10);
      cfg_num_vectors = start ? 9'd5 : 9'(v.cfg);
      in_vld          = (idx < nbytes) && (v.mode != RDY_RANDOM || $urandom_range(3) != 0);
      in_data         = in_vld ? byte_q[idx] : 8'($urandom);
      case (v.mode)
        RDY_RANDOM: out_rdy = 1'($urandom_range(1));
        RDY_STALL:  out_rdy = (cyc >= 20);
        default:    out_rdy = 1'b1;
      endcase
      #1;
      if (v.mode == RDY_STALL && cyc == 19) begin
        check("stall_bytes_taken", 64'(idx), 64'd7);
        check("stall_in_rdy", 64'(in_rdy), 64'd0);
        check("stall_hold_data", 64'({out_vld, out_data}), {31'd0, 1'b1, 32'h03020100});
      end
      if (v.mode == RDY_ALWAYS && idx < nbytes && !in_rdy) bubbles++;
      if (idx == nbytes && in_rdy) drain_err++;
      if (in_vld && in_rdy) begin
        if (idx % 4 == 3) pend = idx / 4;
        idx++;
      end
      if (out_vld && out_rdy) begin
        check("word_data", 64'(out_data), 64'(model_word(k)));
        check("word_tags", 64'({out_lane, out_last_lane, out_last_frame}),
              64'({4'(k % LANES), (k % LANES) == LANES - 1, k == cur_total - 1}));
        if (k == 0) cap_first = out_data;
        cap_last = out_data;
        if (k == cur_total - 1) after_last = 1'b1;
        k++;
      end
      cyc++;
    end
    start  = 1'b0;
    in_vld = 1'b0;
    if (!finished) begin
      check("frame_timeout", 64'd0, 64'd1);
    end else begin
      @(negedge clk);
      #1;
      check("done_one_cycle", 64'(done), 64'd0);
    end
    if (v.mode == RDY_ALWAYS) check("no_bubble", 64'(bubbles), 64'd0);
    check("drain_in_rdy_low", 64'(drain_err), 64'd0);
    nwords = k;
  endtask

  initial begin
    int nw;

    vecs[0] = '{1,   RDY_ALWAYS, PAT_INC,  1'b0, 16,   1'b1, 32'h03020100, 32'h3F3E3D3C};
    vecs[1] = '{1,   RDY_STALL,  PAT_INC,  1'b0, 16,   1'b1, 32'h03020100, 32'h3F3E3D3C};
    vecs[2] = '{3,   RDY_ALWAYS, PAT_INC,  1'b0, 48,   1'b1, 32'h03020100, 32'hBFBEBDBC};
    vecs[3] = '{0,   RDY_ALWAYS, PAT_INC,  1'b0, 0,    1'b0, 32'h0,        32'h0};
    vecs[4] = '{2,   RDY_ALWAYS, PAT_INC,  1'b1, 32,   1'b1, 32'h03020100, 32'h7F7E7D7C};
    vecs[5] = '{300, RDY_ALWAYS, PAT_INC,  1'b0, 4096, 1'b1, 32'h03020100, 32'hFFFEFDFC};
    vecs[6] = '{256, RDY_RANDOM, PAT_RAND, 1'b0, 4096, 1'b0, 32'h0,        32'h0};

    rst_n = 1'b0; start = 1'b0; cfg_num_vectors = '0;
    in_data = '0; in_vld = 1'b0; out_rdy = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_frame(vecs[i], nw);
      check($sformatf("frame%0d_words", i), 64'(nw), 64'(vecs[i].exp_words));
      if (vecs[i].has_fl) begin
        check($sformatf("frame%0d_first", i), 64'(cap_first), 64'(vecs[i].exp_first));
        check($sformatf("frame%0d_last", i), 64'(cap_last), 64'(vecs[i].exp_last));
      end
    end

    // Reset in the middle of word 3 (after its 2nd byte).
    @(negedge clk);
    start = 1'b1; cfg_num_vectors = 9'd1; out_rdy = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 14; i++) begin
      in_vld  = 1'b1;
      in_data = 8'(i);
      @(negedge clk);
    end
    in_vld = 1'b0;
    rst_n  = 1'b0;
    @(negedge clk);
    #1;
    check_all_zero("midreset");
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("midreset_no_done", 64'({done, busy}), 64'd0);

    run_frame('{1, RDY_ALWAYS, PAT_AA, 1'b0, 16, 1'b1, 32'h030201AA, 32'h3F3E3D3C}, nw);
    check("post_reset_words", 64'(nw), 64'd16);
    check("post_reset_first", 64'(cap_first), 64'h030201AA);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/output_word_assembler.md
Name: output_word_assembler

Overview:
- Sits directly downstream of the accelerator output port.
- Consumes the OUTPUT_FIFO_WIDTH-bit output_data/output_vld/output_rdy byte stream and reassembles DATA_WIDTH-bit floating-point words.
- Tags each word with its vector-lane index, last-lane and last-frame flags, and presents the words on a valid/ready interface to the host-side consumer (debug capture, checker, SoC bus bridge).
- One frame is a software-programmed number of VECTOR_LANES-wide vectors.

Parameters:
IN_WIDTH, 8, input stream width; matches the accelerator OUTPUT_FIFO_WIDTH
DATA_WIDTH, 32, assembled word width; must be a multiple of IN_WIDTH
VECTOR_LANES, 16, words per vector
MAX_VECTORS, 256, maximum vectors per frame
CNT_WIDTH, $clog2(MAX_VECTORS+1), width of cfg_num_vectors

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
start  input  1  single-cycle pulse; begins a frame (honoured only in IDLE)
cfg_num_vectors  input  CNT_WIDTH  vectors in the frame; sampled when start is accepted
in_data  input  IN_WIDTH  byte from the accelerator output_data
in_vld  input  1  accelerator output_vld
in_rdy  output  1  driven to the accelerator output_rdy
out_data  output  DATA_WIDTH  assembled word
out_lane  output  $clog2(VECTOR_LANES)  lane index of out_data
out_last_lane  output  1  out_lane == VECTOR_LANES-1
out_last_frame  output  1  final word of the frame
out_vld  output  1  out_data valid
out_rdy  input  1  consumer ready
busy  output  1  state != IDLE
done  output  1  one-cycle pulse when the frame completes

Behaviour:
- Interface decided: one clock, clk; reset rst_n is synchronous and active-low.
- Reset values: all outputs 0. State IDLE, byte counter 0, word counter 0, output register empty.
- BYTES = DATA_WIDTH/IN_WIDTH (4 by default). TOTAL = cfg_num_vectors*VECTOR_LANES words.
- States:
  - IDLE: in_rdy=0.
    - start with cfg_num_vectors != 0: latch TOTAL, go to RUN.
    - start with cfg_num_vectors == 0: done pulses the next cycle and the block stays in IDLE.
    - cfg_num_vectors > MAX_VECTORS: clamp to MAX_VECTORS.
  - RUN: accepts bytes. A byte transfers when in_vld && in_rdy.
  - DRAIN: all TOTAL words have been assembled. in_rdy=0. Waits for the last word to handshake on the output.
- Packing:
  - The first byte of each word goes to bits [IN_WIDTH-1:0]; later bytes fill ascending slices (little-endian).
  - Byte counter wraps from BYTES-1 to 0.
- Output register:
  - Single entry. Loaded in the cycle the BYTES-th byte is accepted; out_vld asserts the following cycle.
  - Latency: last byte accepted at cycle N gives out_vld at cycle N+1.
  - out_* remain stable while out_vld && !out_rdy.
- in_rdy in RUN:
  - = !(byte counter == BYTES-1 && out_vld && !out_rdy).
  - Bytes 0..BYTES-2 of the next word are always accepted, so throughput is 1 byte/cycle with no bubbles when out_rdy stays high.
  - A completing byte and an output handshake in the same cycle are both allowed: the register is refilled in the same cycle.
- Tags:
  - out_lane = word index mod VECTOR_LANES; wraps 15 to 0.
  - out_last_frame = word index == TOTAL-1.
- Completion:
  - Loading word TOTAL-1 moves the block to DRAIN.
  - Handshake of the out_last_frame word moves the block to IDLE with done=1 for that one cycle.
  - busy drops in the same cycle done rises.
- start while busy: ignored. No counters or configuration change.
- in_vld in IDLE/DRAIN: no byte accepted, because in_rdy=0. Bytes stay in the upstream FIFO.
- Reset mid-frame: the next clk edge with rst_n=0 clears all state. A partially assembled word is discarded. done does not pulse.

Test Plan:
1. Frame, no backpressure: cfg_num_vectors=1, start, 64 bytes 0x00..0x3F, out_rdy=1 -> 16 words; word0=0x03020100, word15=0x3F3E3D3C; lanes 0..15; out_last_lane and out_last_frame only on word15; done 1 cycle after the word15 handshake; in_rdy never low in RUN.
2. Backpressure: same frame, out_rdy=0 from word0 -> in_rdy drops after 3 bytes of word1; out_data holds 0x03020100; releasing out_rdy resumes with no byte lost or duplicated.
3. Multi-vector wrap: cfg_num_vectors=3 -> 48 words; out_lane wraps 15 to 0 twice; out_last_lane on words 15, 31, 47; out_last_frame only on word 47.
4. Zero and ignored start: cfg_num_vectors=0 start -> done next cycle, busy stays 0, in_rdy=0. A second start during RUN with cfg=5 -> frame length unchanged.
5. Reset mid-word: reset after 2 bytes of word3 -> all outputs 0 and state IDLE. A new frame starting with byte 0xAA packs 0xAA into bits [7:0] of word0.
6. Random out_rdy, 50% duty, cfg_num_vectors=MAX_VECTORS -> 4096 words in order; byte order and tags match the reference model.
